obi_apb_splitter_n: RTL and testbench

Parametrised OBI-subordinate to N-port APB bridge. It replaces the fixed five-target crossbar-based splitter in the peripheral interconnect subsystem. It decodes one OBI initiator onto NUM_TARGETS equal-sized APB windows and runs the APB protocol with its own FSM. It adds per-target enable masking, error responses for unmapped or disabled targets, a PREADY timeout, and a saturating error counter.

---
 rtl/obi_apb_splitter_pkg.sv | 34 +++
 rtl/obi_apb_addr_decode.sv | 42 ++++
 rtl/obi_apb_splitter_n.sv | 224 ++++++++++++++++++++++
 tb/tb_obi_apb_splitter_n.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_apb_splitter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : obi_apb_splitter_pkg
// Description : Shared types and helpers for the OBI-to-N-port APB splitter.
//               Provides the bridge FSM state type, the window-index decode
//               helper and the error-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package obi_apb_splitter_pkg;

    // Width of the saturating error-response counter.
    localparam int unsigned c_ERR_CNT_W = 8;

    // Bridge FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Window index of an address relative to the base of target 0.
    // Window size is a power of two, so the divide reduces to a shift.
    // Only meaningful when the address lies above the base.
    function automatic logic [63:0] addr_to_idx(
        input logic [63:0] addr,
        input logic [63:0] base,
        input int unsigned ss_log2
    );
        return (addr - base) >> ss_log2;
    endfunction

endpackage : obi_apb_splitter_pkg
`default_nettype wire

// File: rtl/obi_apb_addr_decode.sv
`default_nettype none
// ============================================================================
// Module      : obi_apb_addr_decode
// Description : Combinational address decode onto NUM_TARGETS equal windows.
// Ports       : i_addr   - OBI request address
//               o_hit    - address falls inside one of the target windows
//               o_idx    - index of the selected window (valid when o_hit)
//               o_offset - offset within the window, zero-extended
// Revision    : 1.0 - initial release
// ============================================================================
module obi_apb_addr_decode
    import obi_apb_splitter_pkg::*;
#(
    parameter int unsigned        NUM_TARGETS = 5,
    parameter int unsigned        OBI_AW      = 32,
    parameter int unsigned        APB_AW      = 32,
    parameter logic [OBI_AW-1:0]  ADDR_BASE   = 32'h0105_0000,
    parameter int unsigned        SS_SIZE     = 32'h1000,
    parameter int unsigned        IDX_W       = 3
) (
    input  logic [OBI_AW-1:0] i_addr,
    output logic              o_hit,
    output logic [IDX_W-1:0]  o_idx,
    output logic [APB_AW-1:0] o_offset
);

    // 64-bit arithmetic keeps the window end from wrapping when the
    // decoded region sits at the top of the OBI address space.
    localparam logic [63:0]       c_BASE     = 64'(ADDR_BASE);
    localparam logic [63:0]       c_END      = c_BASE + 64'(NUM_TARGETS) * 64'(SS_SIZE);
    localparam int unsigned       c_SS_LOG2  = $clog2(SS_SIZE);
    localparam logic [OBI_AW-1:0] c_OFF_MASK = OBI_AW'(SS_SIZE - 1);

    logic [63:0] w_addr64;

    assign w_addr64 = 64'(i_addr);
    assign o_hit    = (w_addr64 >= c_BASE) && (w_addr64 < c_END);
    assign o_idx    = IDX_W'(addr_to_idx(w_addr64, c_BASE, c_SS_LOG2));
    assign o_offset = APB_AW'(i_addr & c_OFF_MASK);

endmodule : obi_apb_addr_decode
`default_nettype wire

// File: rtl/obi_apb_splitter_n.sv
`default_nettype none
// ============================================================================
// Module      : obi_apb_splitter_n
// Description : OBI subordinate bridging one initiator onto NUM_TARGETS APB
//               windows. Single outstanding transaction, per-target enable
//               mask sampled at grant, error responses for unmapped/disabled
//               targets, PREADY timeout and a saturating error counter.
// Ports       : clk, reset_n         - clock, asynchronous active-low reset
//               obi_*                - OBI request/response channel (+parity)
//               tgt_en               - per-target enable mask
//               err_clr / err_cnt    - error counter clear / value
//               APB_*                - shared APB bus, one-hot PSEL, packed
//                                      per-target PRDATA/PREADY/PSLVERR
// Revision    : 1.0 - initial release
// ============================================================================
module obi_apb_splitter_n
    import obi_apb_splitter_pkg::*;
#(
    parameter int unsigned       NUM_TARGETS = 5,
    parameter int unsigned       OBI_AW      = 32,
    parameter int unsigned       OBI_DW      = 32,
    parameter int unsigned       OBI_IDW     = 1,
    parameter int unsigned       APB_AW      = 32,
    parameter logic [OBI_AW-1:0] ADDR_BASE   = 32'h0105_0000,
    parameter int unsigned       SS_SIZE     = 32'h1000,
    parameter int unsigned       TIMEOUT_CYC = 255
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          obi_req,
    input  logic                          obi_reqpar,
    input  logic [OBI_AW-1:0]             obi_addr,
    input  logic                          obi_we,
    input  logic [OBI_DW/8-1:0]           obi_be,
    input  logic [OBI_DW-1:0]             obi_wdata,
    input  logic [OBI_IDW-1:0]            obi_aid,
    input  logic                          obi_rready,
    input  logic                          obi_rreadypar,
    output logic                          obi_gnt,
    output logic                          obi_gntpar,
    output logic                          obi_rvalid,
    output logic                          obi_rvalidpar,
    output logic [OBI_DW-1:0]             obi_rdata,
    output logic                          obi_err,
    output logic [OBI_IDW-1:0]            obi_rid,
    input  logic [NUM_TARGETS-1:0]        tgt_en,
    input  logic                          err_clr,
    output logic [c_ERR_CNT_W-1:0]        err_cnt,
    output logic [APB_AW-1:0]             APB_PADDR,
    output logic [OBI_DW-1:0]             APB_PWDATA,
    output logic                          APB_PWRITE,
    output logic [OBI_DW/8-1:0]           APB_PSTRB,
    output logic                          APB_PENABLE,
    output logic [NUM_TARGETS-1:0]        APB_PSEL,
    input  logic [NUM_TARGETS*OBI_DW-1:0] APB_PRDATA,
    input  logic [NUM_TARGETS-1:0]        APB_PREADY,
    input  logic [NUM_TARGETS-1:0]        APB_PSLVERR
);

    localparam int unsigned c_IDX_W    = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
    localparam logic [7:0]  c_TMO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   w_hit;
    logic [c_IDX_W-1:0]     w_idx;
    logic [APB_AW-1:0]      w_offset;
    logic                   w_hs;
    logic                   w_rsp_hs;
    logic                   w_tgt_ok;
    logic                   w_pready;
    logic                   w_pslverr;
    logic [OBI_DW-1:0]      w_prdata;
    logic                   w_tmo;
    logic [NUM_TARGETS-1:0] w_psel_1h;
    logic                   w_unused_par;

    logic [c_IDX_W-1:0]     r_idx;
    logic [APB_AW-1:0]      r_paddr;
    logic [OBI_DW-1:0]      r_wdata;
    logic [OBI_DW/8-1:0]    r_pstrb;
    logic                   r_we;
    logic [OBI_IDW-1:0]     r_rid;
    logic [OBI_DW-1:0]      r_rdata;
    logic                   r_err;
    logic [7:0]             r_tcnt;
    logic [c_ERR_CNT_W-1:0] r_err_cnt;

    // Input parities are not checked.
    assign w_unused_par = obi_reqpar ^ obi_rreadypar;

    obi_apb_addr_decode #(
        .NUM_TARGETS (NUM_TARGETS),
        .OBI_AW      (OBI_AW),
        .APB_AW      (APB_AW),
        .ADDR_BASE   (ADDR_BASE),
        .SS_SIZE     (SS_SIZE),
        .IDX_W       (c_IDX_W)
    ) u_decode (
        .i_addr   (obi_addr),
        .o_hit    (w_hit),
        .o_idx    (w_idx),
        .o_offset (w_offset)
    );

    assign obi_gnt       = obi_req && (r_state == IDLE);
    assign obi_gntpar    = ~obi_gnt;
    assign obi_rvalid    = (r_state == RESP);
    assign obi_rvalidpar = ~obi_rvalid;
    assign obi_rdata     = r_rdata;
    assign obi_err       = r_err;
    assign obi_rid       = r_rid;
    assign err_cnt       = r_err_cnt;

    assign APB_PADDR  = r_paddr;
    assign APB_PWDATA = r_wdata;
    assign APB_PWRITE = r_we;
    assign APB_PSTRB  = r_pstrb;

    assign w_hs      = obi_gnt;
    assign w_rsp_hs  = obi_rvalid && obi_rready;
    // Enable mask is only looked at here, so later tgt_en changes cannot
    // disturb the transaction already in flight.
    assign w_tgt_ok  = w_hit && tgt_en[w_idx];
    assign w_pready  = APB_PREADY[r_idx];
    assign w_pslverr = APB_PSLVERR[r_idx];
    assign w_prdata  = APB_PRDATA[r_idx*OBI_DW +: OBI_DW];
    assign w_tmo     = (r_tcnt == c_TMO_LAST);
    assign w_psel_1h = NUM_TARGETS'(1) << r_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PSEL/PENABLE decode straight from the state so that an asynchronous
    // reset drops them without waiting for a clock.
    always_comb begin
        w_state_nxt = r_state;
        APB_PSEL    = '0;
        APB_PENABLE = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hs) begin
                    w_state_nxt = w_tgt_ok ? SETUP : RESP;
                end
            end
            SETUP: begin
                APB_PSEL    = w_psel_1h;
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                APB_PSEL    = w_psel_1h;
                APB_PENABLE = 1'b1;
                if (w_pready || w_tmo) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (w_rsp_hs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx     <= '0;
            r_paddr   <= '0;
            r_wdata   <= '0;
            r_pstrb   <= '0;
            r_we      <= 1'b0;
            r_rid     <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_tcnt    <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_hs) begin
                r_idx   <= w_idx;
                r_paddr <= w_offset;
                r_wdata <= obi_wdata;
                r_pstrb <= obi_we ? obi_be : '0;
                r_we    <= obi_we;
                r_rid   <= obi_aid;
                // Decode failures answer directly from IDLE; a good decode
                // overwrites these when the APB access completes.
                r_err   <= ~w_tgt_ok;
                r_rdata <= '0;
            end

            if (r_state == SETUP) begin
                r_tcnt <= '0;
            end

            // PREADY wins over a timeout landing in the same cycle.
            if (r_state == ACCESS) begin
                if (w_pready) begin
                    r_err   <= w_pslverr;
                    r_rdata <= (r_we || w_pslverr) ? '0 : w_prdata;
                end else if (w_tmo) begin
                    r_err   <= 1'b1;
                    r_rdata <= '0;
                end else begin
                    r_tcnt <= r_tcnt + 8'd1;
                end
            end

            if (err_clr) begin
                r_err_cnt <= '0;
            end else if (w_rsp_hs && r_err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

endmodule : obi_apb_splitter_n
`default_nettype wire

// File: tb/tb_obi_apb_splitter_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_obi_apb_splitter_n
// Description : Self-checking bench for obi_apb_splitter_n. A responder
//               models N APB targets with configurable wait states; expected
//               responses come from a window/arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obi_apb_splitter_n;

    localparam int          N    = 5;
    localparam int          DW   = 32;
    localparam int          TO   = 4;
    localparam logic [31:0] BASE = 32'h0105_0000;
    localparam longint      SS   = 64'h1000;

    logic            clk;
    logic            reset_n;
    logic            obi_req, obi_reqpar;
    logic [31:0]     obi_addr;
    logic            obi_we;
    logic [3:0]      obi_be;
    logic [31:0]     obi_wdata;
    logic [0:0]      obi_aid;
    logic            obi_rready, obi_rreadypar;
    logic            obi_gnt, obi_gntpar, obi_rvalid, obi_rvalidpar;
    logic [31:0]     obi_rdata;
    logic            obi_err;
    logic [0:0]      obi_rid;
    logic [N-1:0]    tgt_en;
    logic            err_clr;
    logic [7:0]      err_cnt;
    logic [31:0]     APB_PADDR, APB_PWDATA;
    logic            APB_PWRITE, APB_PENABLE;
    logic [3:0]      APB_PSTRB;
    logic [N-1:0]    APB_PSEL, pready_bus, pslverr_bus;
    logic [N*DW-1:0] prdata_bus;

    int              n_checks = 0;
    int              n_err    = 0;
    int              m_err_cnt = 0;
    logic [31:0]     tgt_data [N];
    int              cfg_wait = 0;
    logic            cfg_slverr = 1'b0;
    int              acc_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obi_apb_splitter_n #(
        .NUM_TARGETS (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .obi_req       (obi_req),
        .obi_reqpar    (obi_reqpar),
        .obi_addr      (obi_addr),
        .obi_we        (obi_we),
        .obi_be        (obi_be),
        .obi_wdata     (obi_wdata),
        .obi_aid       (obi_aid),
        .obi_rready    (obi_rready),
        .obi_rreadypar (obi_rreadypar),
        .obi_gnt       (obi_gnt),
        .obi_gntpar    (obi_gntpar),
        .obi_rvalid    (obi_rvalid),
        .obi_rvalidpar (obi_rvalidpar),
        .obi_rdata     (obi_rdata),
        .obi_err       (obi_err),
        .obi_rid       (obi_rid),
        .tgt_en        (tgt_en),
        .err_clr       (err_clr),
        .err_cnt       (err_cnt),
        .APB_PADDR     (APB_PADDR),
        .APB_PWDATA    (APB_PWDATA),
        .APB_PWRITE    (APB_PWRITE),
        .APB_PSTRB     (APB_PSTRB),
        .APB_PENABLE   (APB_PENABLE),
        .APB_PSEL      (APB_PSEL),
        .APB_PRDATA    (prdata_bus),
        .APB_PREADY    (pready_bus),
        .APB_PSLVERR   (pslverr_bus)
    );

    // APB targets: ready once cfg_wait ACCESS cycles have elapsed.
    always @(posedge clk) acc_cnt <= APB_PENABLE ? acc_cnt + 1 : 0;

    always_comb begin
        prdata_bus = '0;
        pready_bus = '0;
        for (int i = 0; i < N; i++) begin
            prdata_bus[i*DW +: DW] = tgt_data[i];
            pready_bus[i] = APB_PSEL[i] && APB_PENABLE && (acc_cnt >= cfg_wait);
        end
    end
    assign pslverr_bus = {N{cfg_slverr}};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_psel"},      APB_PSEL,      0);
        check({tag, "_penable"},   APB_PENABLE,   0);
        check({tag, "_paddr"},     APB_PADDR,     0);
        check({tag, "_pstrb_pw"},  {APB_PSTRB, APB_PWRITE, APB_PWDATA}, 0);
        check({tag, "_rvalid"},    obi_rvalid,    0);
        check({tag, "_gnt"},       obi_gnt,       0);
        check({tag, "_pars"},      {obi_gntpar, obi_rvalidpar}, 2'b11);
        check({tag, "_resp"},      {obi_rdata, obi_err, obi_rid}, 0);
        check({tag, "_err_cnt"},   err_cnt,       0);
    endtask

    // One complete OBI transaction with model-derived expectations.
    task automatic do_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                          input logic [31:0] wdata, input logic aid, input logic [N-1:0] en,
                          input int waits, input logic slverr, input int rdelay, input logic clr);
        longint unsigned a;
        bit          hit, ok, tmo, err;
        int          idx, nacc, lat, ps_c, pe_c;
        bit          apb_bad, par_bad, stab_bad;
        logic [N-1:0] exp_psel;
        logic [31:0] exp_rdata, exp_paddr, h_rdata;
        logic [3:0]  exp_pstrb;
        logic        h_err, h_rid;

        a    = 64'(addr);
        hit  = (a >= 64'(BASE)) && (a < 64'(BASE) + N * SS);
        idx  = hit ? int'((a - 64'(BASE)) / SS) : 0;
        ok   = hit && en[idx];
        tmo  = ok && (waits + 1 > TO);
        nacc = !ok ? 0 : (tmo ? TO : waits + 1);
        err  = !ok || tmo || slverr;
        exp_rdata = (err || we) ? 32'h0 : tgt_data[idx];
        exp_psel  = '0;
        if (ok) exp_psel[idx] = 1'b1;
        exp_paddr = 32'(a % SS);
        exp_pstrb = we ? be : 4'h0;

        @(negedge clk);
        tgt_en = en; cfg_wait = waits; cfg_slverr = slverr;
        obi_req = 1'b1; obi_addr = addr; obi_we = we; obi_be = be;
        obi_wdata = wdata; obi_aid = aid;
        #1;
        check("gnt_idle", obi_gnt, 1);
        @(posedge clk); #1;
        obi_req = 1'b0;
        tgt_en  = ~en;
        lat = 1; ps_c = 0; pe_c = 0; apb_bad = 0; par_bad = 0; stab_bad = 0;
        while (!obi_rvalid && lat < 40) begin
            if (APB_PSEL != '0) begin
                ps_c++;
                if (APB_PENABLE) pe_c++;
                if (APB_PSEL !== exp_psel || APB_PADDR !== exp_paddr || APB_PSTRB !== exp_pstrb ||
                    APB_PWRITE !== we || APB_PWDATA !== wdata) apb_bad = 1;
            end else if (APB_PENABLE) begin
                apb_bad = 1;
            end
            if (obi_gntpar !== ~obi_gnt || obi_rvalidpar !== ~obi_rvalid) par_bad = 1;
            @(posedge clk); #1;
            lat++;
        end
        check("latency",    lat,  ok ? 2 + nacc : 1);
        check("psel_cyc",   ps_c, ok ? 1 + nacc : 0);
        check("penable_cyc", pe_c, nacc);
        check("apb_fields", apb_bad, 0);
        check("parity",     {par_bad, obi_rvalidpar}, 0);
        check("rvalid",     obi_rvalid, 1);
        check("rdata",      obi_rdata, exp_rdata);
        check("err",        obi_err, err);
        check("rid",        obi_rid, aid);

        h_rdata = obi_rdata; h_err = obi_err; h_rid = obi_rid[0];
        for (int k = 0; k < rdelay; k++) begin
            obi_req = 1'b1;
            @(posedge clk); #1;
            if (!obi_rvalid || obi_rdata !== h_rdata || obi_err !== h_err ||
                obi_rid[0] !== h_rid || obi_gnt !== 1'b0 || APB_PSEL !== '0) stab_bad = 1;
        end
        check("resp_stable", stab_bad, 0);

        obi_req = 1'b0; obi_rready = 1'b1; err_clr = clr;
        @(posedge clk);
        if (clr) m_err_cnt = 0;
        else if (err && m_err_cnt < 255) m_err_cnt++;
        #1;
        obi_rready = 1'b0; err_clr = 1'b0;
        check("rvalid_drop", obi_rvalid, 0);
        check("err_cnt",     err_cnt, m_err_cnt);
    endtask

    initial begin
        logic [31:0] ra;
        logic [N-1:0] ren;
        reset_n = 1'b0; obi_req = 1'b0; obi_reqpar = 1'b1; obi_addr = '0; obi_we = 1'b0;
        obi_be = '0; obi_wdata = '0; obi_aid = '0; obi_rready = 1'b0; obi_rreadypar = 1'b1;
        tgt_en = '1; err_clr = 1'b0;
        for (int i = 0; i < N; i++) tgt_data[i] = $urandom;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk); reset_n = 1'b1;

        // Zero-wait write to target 2.
        do_txn(32'h0105_2004, 1, 4'b0011, 32'hA5A5_0001, 1'b1, 5'b11111, 0, 0, 0, 0);
        // Read target 4 with three wait states.
        tgt_data[4] = 32'h1234_5678;
        do_txn(32'h0105_4000, 0, 4'hF, 32'h0, 1'b1, 5'b11111, 3, 0, 0, 0);
        // Unmapped read.
        do_txn(32'h0105_5000, 0, 4'hF, 32'h0, 1'b0, 5'b11111, 0, 0, 0, 0);
        // Disabled target, then slave error.
        do_txn(32'h0105_1000, 1, 4'hF, 32'hDEAD_BEEF, 1'b0, 5'b11101, 0, 0, 0, 0);
        do_txn(32'h0105_1000, 1, 4'hF, 32'hDEAD_BEEF, 1'b1, 5'b11111, 1, 1, 0, 0);
        // Timeout with stalled response ready.
        do_txn(32'h0105_0FFC, 0, 4'hF, 32'h0, 1'b1, 5'b11111, 8, 0, 5, 0);
        // Just below the base address.
        do_txn(32'h0104_FFFC, 0, 4'hF, 32'h0, 1'b0, 5'b11111, 0, 0, 0, 0);

        // Randomised traffic.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) tgt_data[i] = $urandom;
            ra  = BASE + 32'($urandom_range(0, 6 * 32'h1000 - 4)) & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) ra = $urandom;
            ren = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            do_txn(ra, 1'($urandom), 4'($urandom), $urandom, 1'($urandom), ren,
                   $urandom_range(0, 5), ($urandom_range(0, 3) == 0), $urandom_range(0, 2), 0);
        end

        // Saturate the error counter, then clear together with another error.
        for (int t = 0; t < 256; t++)
            do_txn(32'h0200_0000, 0, 4'hF, 32'h0, 1'b0, 5'b11111, 0, 0, 0, 0);
        check("err_cnt_sat", err_cnt, 255);
        do_txn(32'h0105_5000, 0, 4'hF, 32'h0, 1'b0, 5'b11111, 0, 0, 0, 1);

        // Reset during ACCESS.
        do_txn(32'h0105_5000, 0, 4'hF, 32'h0, 1'b0, 5'b11111, 0, 0, 0, 0);
        @(negedge clk);
        tgt_en = '1; cfg_wait = 20; obi_req = 1'b1; obi_addr = 32'h0105_3010; obi_we = 1'b1;
        @(posedge clk); #1; obi_req = 1'b0;
        @(posedge clk); #1;
        check("penable_pre_reset", {APB_PENABLE, APB_PSEL}, {1'b1, 5'b01000});
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        m_err_cnt = 0;
        @(negedge clk); reset_n = 1'b1;
        do_txn(32'h0105_0008, 0, 4'hF, 32'h0, 1'b0, 5'b11111, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_obi_apb_splitter_n
`default_nettype wire
